// File: rtl/vga_capture_pkg.sv
// rtl/vga_capture_pkg.sv - shared constants and types for the VGA board capture
package vga_capture_pkg;

    localparam int VGA_H_TOTAL      = 800;
    localparam int VGA_H_SYNC_START = 656;
    localparam int VGA_V_TOTAL      = 525;
    localparam int VGA_V_SYNC_START = 490;
    localparam int VGA_TIMEOUT      = 1600;

    localparam int LOG_WIDTH  = 6;
    localparam int LOG_HEIGHT = 5;
    localparam int BOARD_SIZE = 2048;

    localparam int WIN_H_START = 64;
    localparam int WIN_H_END   = 576;
    localparam int WIN_V_START = 112;
    localparam int WIN_V_END   = 368;

    // PMOD byte is {hsync, B0, G0, R0, vsync, B1, G1, R1}
    localparam int PMOD_HSYNC = 7;
    localparam int PMOD_VSYNC = 3;
    localparam int PMOD_G1    = 1;
    localparam int PMOD_R1    = 0;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } sync_state_e;

endpackage

// File: rtl/vga_sync_tracker.sv
// rtl/vga_sync_tracker.sv - input register, sync edge detect, raster counters and lock FSM
module vga_sync_tracker
    import vga_capture_pkg::*;
#(
    parameter int H_TOTAL         = VGA_H_TOTAL,
    parameter int H_SYNC_START    = VGA_H_SYNC_START,
    parameter int V_TOTAL         = VGA_V_TOTAL,
    parameter int V_SYNC_START    = VGA_V_SYNC_START,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int TIMEOUT         = VGA_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] vga_i,
    output logic [9:0] h_o,
    output logic [9:0] v_o,
    output logic       cell_bit_o,
    output logic       locked_o,
    output logic       vsync_edge_o,
    output logic       sync_err_o
);

    localparam logic POL = (SYNC_ACTIVE_LOW != 0);
    // Syncs reset to their asserted level so a source already in sync cannot fake an edge
    localparam logic [3:0] S_RST = {~POL, ~POL, 2'b00};

    // Only the syncs and the R1/G1 pair matter downstream: {hsync, vsync, G1, R1}
    logic [3:0]  s_q, p_q;
    logic        unused_pmod;
    logic        hedge, vedge;
    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [10:0] per_q, per_d;
    logic [9:0]  lines_q, lines_d, lines_inc;
    logic        seen_q, seen_d;
    logic        sync_err_q, sync_err_d;
    logic        h_wrap, period_bad, timeout, lines_bad;
    sync_state_e state_q, state_d;

    assign unused_pmod = ^{vga_i[6:4], vga_i[2]};

    assign hedge = (s_q[3] ^ POL) & ~(p_q[3] ^ POL);
    assign vedge = (s_q[2] ^ POL) & ~(p_q[2] ^ POL);

    always_comb begin
        h_wrap = (h_q == 10'(H_TOTAL - 1));
        h_d    = h_q + 10'd1;
        if (hedge)       h_d = 10'(H_SYNC_START);
        else if (h_wrap) h_d = '0;

        v_d = v_q;
        if (vedge)                 v_d = 10'(V_SYNC_START);
        else if (h_wrap && !hedge) v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;

        per_d      = hedge ? '0 : ((&per_q) ? per_q : per_q + 11'd1);
        lines_inc  = (hedge && !(&lines_q)) ? lines_q + 10'd1 : lines_q;
        lines_d    = vedge ? '0 : lines_inc;
        period_bad = hedge && seen_q && (per_q != 11'(H_TOTAL - 1));
        timeout    = !hedge && (per_q >= 11'(TIMEOUT - 1));
        lines_bad  = vedge && (lines_inc != 10'(V_TOTAL));

        seen_d     = seen_q | hedge;
        state_d    = state_q;
        sync_err_d = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (vedge) begin
                    state_d = ST_MEASURE;
                    seen_d  = hedge;
                end
            end
            ST_MEASURE, ST_LOCKED: begin
                if (period_bad || timeout || lines_bad) begin
                    state_d    = ST_SEARCH;
                    sync_err_d = 1'b1;
                end else if (vedge) begin
                    state_d = ST_LOCKED;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q        <= S_RST;
            p_q        <= S_RST;
            h_q        <= '0;
            v_q        <= '0;
            per_q      <= '0;
            lines_q    <= '0;
            seen_q     <= 1'b0;
            sync_err_q <= 1'b0;
            state_q    <= ST_SEARCH;
        end else begin
            s_q        <= {vga_i[PMOD_HSYNC], vga_i[PMOD_VSYNC], vga_i[PMOD_G1], vga_i[PMOD_R1]};
            p_q        <= s_q;
            h_q        <= h_d;
            v_q        <= v_d;
            per_q      <= per_d;
            lines_q    <= lines_d;
            seen_q     <= seen_d;
            sync_err_q <= sync_err_d;
            state_q    <= state_d;
        end
    end

    // h_q/v_q track the pixel held in P, so the cell bit is taken from P
    assign h_o          = h_q;
    assign v_o          = v_q;
    assign cell_bit_o   = p_q[1] & p_q[0];
    assign locked_o     = (state_q == ST_LOCKED);
    assign vsync_edge_o = vedge;
    assign sync_err_o   = sync_err_q;

endmodule

// File: rtl/vga_board_capture.sv
// rtl/vga_board_capture.sv - samples cell centres of a locked 640x480 raster into a 64x32 bitmap
module vga_board_capture
    import vga_capture_pkg::*;
#(
    parameter int H_TOTAL         = VGA_H_TOTAL,
    parameter int H_SYNC_START    = VGA_H_SYNC_START,
    parameter int V_TOTAL         = VGA_V_TOTAL,
    parameter int V_SYNC_START    = VGA_V_SYNC_START,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int TIMEOUT         = VGA_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_in,
    input  logic [10:0] rd_addr,
    output logic        rd_data,
    output logic        locked,
    output logic        sync_err,
    output logic        frame_done,
    output logic [11:0] live_count,
    output logic [7:0]  frame_count
);

    logic [9:0]  h, v;
    logic        cell_bit, trk_locked, vsync_edge;
    logic        sample;
    logic [10:0] wr_addr;
    logic        mem [BOARD_SIZE];
    logic        rd_data_q;
    logic [11:0] samp_q, samp_d, acc_q, acc_d, live_q, live_d;
    logic [7:0]  fc_q, fc_d;
    logic        fd_q, fd_d;

    vga_sync_tracker #(
        .H_TOTAL        (H_TOTAL),
        .H_SYNC_START   (H_SYNC_START),
        .V_TOTAL        (V_TOTAL),
        .V_SYNC_START   (V_SYNC_START),
        .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW),
        .TIMEOUT        (TIMEOUT)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .vga_i       (vga_in),
        .h_o         (h),
        .v_o         (v),
        .cell_bit_o  (cell_bit),
        .locked_o    (trk_locked),
        .vsync_edge_o(vsync_edge),
        .sync_err_o  (sync_err)
    );

    assign sample = trk_locked
                 && (h >= 10'(WIN_H_START)) && (h < 10'(WIN_H_END))
                 && (v >= 10'(WIN_V_START)) && (v < 10'(WIN_V_END))
                 && (h[2:0] == 3'd3) && (v[2:0] == 3'd3);
    assign wr_addr = {v[LOG_HEIGHT+2:3], h[LOG_WIDTH+2:3]};

    always_ff @(posedge clk) begin
        if (sample) mem[wr_addr] <= cell_bit;
    end

    always_comb begin
        samp_d = samp_q;
        acc_d  = acc_q;
        live_d = live_q;
        fc_d   = fc_q;
        fd_d   = 1'b0;
        if (vsync_edge) begin
            // Only a fully sampled board is reported; partial frames are dropped
            if (trk_locked && samp_q == 12'(BOARD_SIZE)) begin
                fd_d   = 1'b1;
                live_d = acc_q;
                fc_d   = fc_q + 8'd1;
            end
            samp_d = '0;
            acc_d  = '0;
        end else if (sample) begin
            samp_d = samp_q + 12'd1;
            acc_d  = acc_q + {11'd0, cell_bit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q    <= '0;
            acc_q     <= '0;
            live_q    <= '0;
            fc_q      <= '0;
            fd_q      <= 1'b0;
            rd_data_q <= 1'b0;
        end else begin
            samp_q    <= samp_d;
            acc_q     <= acc_d;
            live_q    <= live_d;
            fc_q      <= fc_d;
            fd_q      <= fd_d;
            rd_data_q <= mem[rd_addr];
        end
    end

    assign locked      = trk_locked;
    assign frame_done  = fd_q;
    assign live_count  = live_q;
    assign frame_count = fc_q;
    assign rd_data     = rd_data_q;

endmodule

// File: doc/vga_board_capture.md
# vga_board_capture

Receive-side decoder for the TinyVGA PMOD byte produced by the Game of Life display path. It recovers horizontal/vertical timing from the embedded syncs and locks to a 640x480 raster. It then samples the centre pixel of every 8x8 cell and rebuilds the 64x32 board into an internal bitmap readable by a test/debug host. It sits on the output side of the display, in silicon loopback or on the bench, and reports per-frame live-cell counts.

## Interface
Parameters:
- H_TOTAL, 800, clocks per line
- H_SYNC_START, 656, horizontal position of the first pixel with hsync asserted
- V_TOTAL, 525, lines per frame
- V_SYNC_START, 490, vertical position of the first line with vsync asserted
- SYNC_ACTIVE_LOW, 1, sync polarity
- TIMEOUT, 1600, clocks without an hsync edge before lock is dropped

Ports:
- clk  in  1  pixel clock, one pixel per cycle
- rst_n  in  1  asynchronous active-low reset
- vga_in  in  8  PMOD byte {hsync, B0, G0, R0, vsync, B1, G1, R1}
- rd_addr  in  11  board read address {row[4:0], col[5:0]}
- rd_data  out  1  cell state at rd_addr
- locked  out  1  raster lock
- sync_err  out  1  one-cycle pulse on a timing violation while MEASURE/LOCKED
- frame_done  out  1  one-cycle pulse when a complete board has been captured
- live_count  out  12  live cells in the last completed frame (0..2048)
- frame_count  out  8  completed captures, wraps 255->0

## Operation
- vga_in is registered once (stage S). All decoding uses S and its previous value (P).
- Sync edge: asserted in S and not asserted in P, polarity per SYNC_ACTIVE_LOW.
- On an hsync edge, h loads H_SYNC_START. Otherwise h increments and wraps H_TOTAL-1 -> 0.
- v increments on the h wrap. On a vsync edge, v loads V_SYNC_START. Load beats increment in the same cycle.
- FSM states:
  - SEARCH: wait for a vsync edge, then go to MEASURE.
  - MEASURE: each hsync edge after the first must arrive exactly H_TOTAL clocks after the previous one. At the next vsync edge, if exactly V_TOTAL hsync edges were seen, go to LOCKED; otherwise go to SEARCH.
  - LOCKED: the same checks run continuously.
  - Any violation (wrong period, wrong line count, or TIMEOUT clocks without an hsync edge) sends MEASURE or LOCKED to SEARCH and pulses sync_err.
- Period counter is 11 bits and saturates.
- Capture happens only in LOCKED:
  - Sample condition: 64 <= h < 576, 112 <= v < 368, h[2:0]==3, v[2:0]==3.
  - Write bitmap[{v[7:3], h[8:3]}] <= R1 & G1.
  - On each sample, the sample counter increments and the live accumulator adds the sampled bit.
- At each vsync edge in LOCKED:
  - If the sample counter == 2048: latch live_count, pulse frame_done, increment frame_count.
  - In all cases, clear the sample counter and the accumulator.
  - The first frame after lock therefore reports only if it was captured in full.
- The bitmap is not cleared by reset; its contents are undefined until the first frame_done.

## Timing
- Reset values: locked 0, sync_err 0, frame_done 0, live_count 0, frame_count 0, rd_data 0, FSM in SEARCH.
- Reset takes effect immediately. Mid-frame reset discards the partial capture and requires a full relock.
- Input latency: 1 cycle to S. Edge detect is combinational on S/P.
- locked: 1 in the cycle after the vsync edge that completes MEASURE. Drops to 0 in the cycle after the violation is detected, coincident with the sync_err pulse.
- frame_done, latched live_count and incremented frame_count all appear together in the cycle after the vsync edge. live_count holds until the next frame_done.
- rd_data: registered, valid 1 cycle after rd_addr. A read colliding with a write to the same address returns the old value.
- Lock from power-up with a clean source: first vsync edge -> MEASURE, second vsync edge -> LOCKED. First frame_done occurs at the third vsync edge.

## Structure
- Package vga_capture_pkg holds:
  - 640x480 timing constants
  - board dimensions (logWIDTH 6, logHEIGHT 5, BOARD_SIZE 2048)
  - frame window bounds (64, 576, 112, 368)
  - PMOD bit positions
  - FSM state enum
- Sub-module vga_sync_tracker contains the input register, edge detectors, h/v counters, lock FSM, timeout and sync_err. It outputs h, v, locked and vsync_edge.
- The top level contains the sample logic, the 2048x1 bitmap, the accumulators and the read port.

## Test plan
- Reset: hold rst_n low with vga_in toggling -> every output 0. After release, locked stays 0 until the second vsync edge.
- Checkerboard board (cell live iff row^col odd) from an ideal source -> locked after the 2nd vsync edge. At the 3rd vsync edge, frame_done pulses, live_count=1024 and frame_count=1. A readback of all 2048 addresses matches the pattern.
- All-dead frame then all-live frame -> live_count 0, then 2048 on consecutive frame_done pulses. frame_count increments by 1 each time.
- While LOCKED, shorten one line to 799 clocks -> sync_err pulses once, locked falls, no frame_done for that frame. Relock after two clean vsync edges.
- While LOCKED, hold hsync deasserted -> after 1600 clocks without an edge, sync_err pulses and locked goes 0.
- Assert rst_n low mid-frame at v=200 -> outputs clear immediately. After release, the relock sequence repeats and frame_count restarts at 1.
